// File: rtl/instr_mem_responder.sv
// I-cache refill responder: reads DATA_WIDTH/8 consecutive bytes from a byte-wide RAM,
// one address per cycle, and returns them little-endian as one line with a mem_done pulse.
module instr_mem_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_signal,
    input  logic                  mem_signal,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_done,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] ram_a,
    input  logic [7:0]            ram_din,
    output logic                  ram_wr,
    output logic                  busy
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] FULL = CW'(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           issue_cnt, issue_n;
    logic [CW-1:0]           cap_cnt, cap_n;
    logic [ADDR_WIDTH-1:0]   ram_a_n;
    logic                    done_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic                    stalled, stalled_n;
    logic [ADDR_WIDTH-1:0]   base, base_n;
    logic [DATA_WIDTH-1:0]   line, line_n;

    assign ram_wr = 1'b0;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            ram_a     <= '0;
            mem_done  <= 1'b0;
            mem_data  <= '0;
            stalled   <= 1'b0;
        end else begin
            state     <= state_n;
            issue_cnt <= issue_n;
            cap_cnt   <= cap_n;
            ram_a     <= ram_a_n;
            mem_done  <= done_n;
            mem_data  <= data_n;
            stalled   <= stalled_n;
        end
    end

    // Request address and partial line need no reset: both are rewritten before use.
    always_ff @(posedge clk_in) begin
        base <= base_n;
        line <= line_n;
    end

    always_comb begin
        state_n   = state;
        issue_n   = issue_cnt;
        cap_n     = cap_cnt;
        ram_a_n   = ram_a;
        done_n    = mem_done;
        data_n    = mem_data;
        stalled_n = stalled;
        base_n    = base;
        line_n    = line;

        if (!rdy_in) begin
            // The byte on ram_din is lost while paused, so the fetch must restart.
            if (state == FETCH) stalled_n = 1'b1;
        end else if (clear_signal) begin
            state_n   = IDLE;
            done_n    = 1'b0;
            stalled_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_signal) begin
                        base_n  = mem_addr;
                        ram_a_n = mem_addr;
                        issue_n = CW'(1);
                        cap_n   = '0;
                        state_n = FETCH;
                    end
                end
                FETCH: begin
                    if (stalled) begin
                        ram_a_n   = base;
                        issue_n   = CW'(1);
                        cap_n     = '0;
                        stalled_n = 1'b0;
                    end else begin
                        if (issue_cnt < FULL) begin
                            ram_a_n = base + ADDR_WIDTH'(issue_cnt);
                            issue_n = issue_cnt + CW'(1);
                        end
                        for (int i = 0; i < NBYTES; i++) begin
                            if (cap_cnt == CW'(i)) line_n[8*i +: 8] = ram_din;
                        end
                        cap_n = cap_cnt + CW'(1);
                        if (cap_cnt == LAST) begin
                            data_n  = line_n;
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    // mem_signal is still high here; accepting it would start a duplicate refill.
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder; the RAM is modelled as byte(addr) = addr[7:0] + 0x10,
// read combinationally from ram_a.
module tb_instr_mem_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        mem_signal;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [63:0] mem_data;
    logic [31:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic        busy;

    int checks = 0;
    int passed = 0;

    instr_mem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_signal(clear_signal),
        .mem_signal  (mem_signal),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data),
        .ram_a       (ram_a),
        .ram_din     (ram_din),
        .ram_wr      (ram_wr),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    assign ram_din = ram_a[7:0] + 8'h10;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive a request; edge 0 accepts, mem_done is expected after edge 8.
    task automatic refill(input string tag, input logic [31:0] a, input logic [63:0] exp);
        logic [31:0] ea;
        mem_addr   = a;
        mem_signal = 1'b1;
        tick();
        chk({tag, "_acc_ram_a"}, ram_a, a);
        chk({tag, "_acc_busy"}, busy, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            ea = a + 32'(i);
            chk({tag, "_ram_a"}, ram_a, ea);
            chk({tag, "_early_done"}, mem_done, 0);
        end
        tick();
        ea = a + 32'd7;
        chk({tag, "_done"}, mem_done, 1);
        chk({tag, "_data"}, mem_data, exp);
        chk({tag, "_ram_a_hold"}, ram_a, ea);
        tick();
        chk({tag, "_done_pulse"}, mem_done, 0);
        mem_signal = 1'b0;
        tick();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_no_rerequest"}, ram_a, ea);
    endtask

    initial begin
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        clear_signal = 1'b0;
        mem_signal   = 1'b0;
        mem_addr     = 32'h0;

        // Reset
        repeat (3) tick();
        chk("rst_done", mem_done, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_busy", busy, 0);
        rst_in = 1'b1;
        repeat (5) tick();
        chk("idle_ram_a", ram_a, 0);
        chk("idle_busy", busy, 0);

        // Basic refill, then a held request followed by the next line
        refill("basic", 32'h0000_1000, 64'h1716_1514_1312_1110);
        refill("next", 32'h0000_1008, 64'h1F1E_1D1C_1B1A_1918);

        // Address wrap
        refill("wrap", 32'hFFFF_FFFC, 64'h1312_1110_0F0E_0D0C);

        // Flush at edge 4
        mem_addr   = 32'h0000_2000;
        mem_signal = 1'b1;
        repeat (4) tick();
        clear_signal = 1'b1;
        tick();
        clear_signal = 1'b0;
        mem_signal   = 1'b0;
        chk("flush4_busy", busy, 0);
        chk("flush4_ram_a", ram_a, 32'h0000_2003);
        repeat (5) begin
            tick();
            chk("flush4_done", mem_done, 0);
        end

        // Flush on the completion edge
        mem_signal = 1'b1;
        repeat (8) tick();
        chk("flush8_pre", mem_done, 0);
        clear_signal = 1'b1;
        tick();
        clear_signal = 1'b0;
        mem_signal   = 1'b0;
        chk("flush8_done", mem_done, 0);
        chk("flush8_busy", busy, 0);
        tick();
        chk("flush8_after", mem_done, 0);
        refill("postflush", 32'h0000_1000, 64'h1716_1514_1312_1110);

        // Stall at edges 3..5, restart at edge 6, done at edge 14
        mem_addr   = 32'h0000_30F8;
        mem_signal = 1'b1;
        repeat (3) tick();
        chk("stall_pre_ram_a", ram_a, 32'h0000_30FA);
        rdy_in = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_ram_a", ram_a, 32'h0000_30FA);
            chk("stall_busy", busy, 1);
            chk("stall_done", mem_done, 0);
        end
        rdy_in = 1'b1;
        tick();
        chk("resume_ram_a", ram_a, 32'h0000_30F8);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("resume_early_done", mem_done, 0);
        end
        tick();
        chk("resume_done", mem_done, 1);
        chk("resume_data", mem_data, 64'h0F0E_0D0C_0B0A_0908);
        mem_signal = 1'b0;
        rdy_in     = 1'b0;
        tick();
        chk("done_stall_hold", mem_done, 1);
        rdy_in = 1'b1;
        tick();
        chk("done_stall_end", mem_done, 0);
        tick();
        chk("done_stall_idle", busy, 0);

        // Async reset mid-fetch
        mem_addr   = 32'h0000_1000;
        mem_signal = 1'b1;
        repeat (4) tick();
        #2 rst_in = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ram_a", ram_a, 0);
        chk("arst_data", mem_data, 0);
        mem_signal = 1'b0;
        tick();
        rst_in = 1'b1;
        repeat (10) begin
            tick();
            chk("arst_no_done", mem_done, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
